// File: rtl/sv32_pkg.sv
// ============================================================================
// sv32_pkg : shared types and PTE field positions for the Sv32 page-table walker
// Rev 1.0
// ============================================================================
`default_nettype none

package sv32_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_L1_REQ = 3'd1,
    ST_L0_REQ = 3'd2,
    ST_DONE   = 3'd3,
    ST_DRAIN  = 3'd4
  } ptw_state_e;

  localparam int PTE_V         = 0;
  localparam int PTE_R         = 1;
  localparam int PTE_W         = 2;
  localparam int PTE_X         = 3;
  localparam int PTE_U         = 4;
  localparam int PTE_G         = 5;
  localparam int PTE_A         = 6;
  localparam int PTE_D         = 7;
  localparam int PTE_PPN_LSB   = 10;
  localparam int PTE_PPN_MSB   = 31;
  localparam int PAGE_SHIFT    = 12;
  localparam int PTE_SIZE_LOG2 = 2;

  typedef struct packed {
    logic [21:0] ppn;
    logic        u;
    logic        w;
    logic        r;
    logic        x;
    logic        g;
    logic        sup;
  } leaf_t;

endpackage

`default_nettype wire

// File: rtl/sv32_pte_decode.sv
// ============================================================================
// sv32_pte_decode : structural classification of one Sv32 PTE at either level.
// Macro SV32_PTW_SUPERPAGE_EN: accept aligned level-1 leaves as megapages.
// Rev 1.0
// ============================================================================
`default_nettype none

module sv32_pte_decode
  import sv32_pkg::*;
(
  input  logic [31:0] pte,
  input  logic        level1,
  input  logic        write,
  output logic        invalid,
  output logic        pointer,
  output logic        leaf_ok,
  output logic        fault
);

  logic leaf;
  logic misaligned;
  logic ad_fault;
  logic super_fault;
  logic unused_bits;

  assign unused_bits = ^{pte[31:20], pte[9:8], pte[PTE_G], pte[PTE_U]};

  always_comb begin
    invalid    = !pte[PTE_V] || (!pte[PTE_R] && pte[PTE_W]);
    pointer    = !invalid && !pte[PTE_R] && !pte[PTE_X];
    leaf       = !invalid && !pointer;
    misaligned = level1 && (pte[PTE_PPN_LSB +: 10] != 10'd0);
    // Accessed/dirty are never updated in hardware, so a clear bit is a fault.
    ad_fault   = !pte[PTE_A] || (write && !pte[PTE_D]);
`ifdef SV32_PTW_SUPERPAGE_EN
    super_fault = 1'b0;
`else
    super_fault = level1;
`endif
    leaf_ok    = leaf && !misaligned && !ad_fault && !super_fault;
    // Excludes invalid; a pointer is only legal at level 1.
    fault      = (pointer && !level1) || (leaf && !leaf_ok);
  end

endmodule

`default_nettype wire

// File: rtl/sv32_ptw.sv
// ============================================================================
// sv32_ptw : two-level Sv32 hardware page-table walker feeding the TLB fill.
// Macro SV32_PTW_SUPERPAGE_EN: level-1 leaves become 4 MiB megapages.
// Rev 1.0
// ============================================================================
`default_nettype none

module sv32_ptw
  import sv32_pkg::*;
#(
  parameter int PA_W = 34
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [21:0]     satp_ppn,
  input  logic            flush,
  input  logic            walk_req,
  input  logic [19:0]     walk_vpn,
  input  logic            walk_write,
  output logic            walk_busy,
  output logic            walk_done,
  output logic            walk_pf,
  output logic            walk_af,
  output logic [21:0]     pte_ppn,
  output logic            pte_u,
  output logic            pte_w,
  output logic            pte_r,
  output logic            pte_x,
  output logic            pte_g,
  output logic            pte_super,
  output logic            mem_req,
  output logic [PA_W-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [31:0]     mem_rdata,
  input  logic            mem_err
);

  ptw_state_e      state_q, state_d;
  logic [9:0]      vpn0_q, vpn0_d;
  logic            write_q, write_d;
  logic [PA_W-1:0] mem_addr_q, mem_addr_d;
  logic            pf_q, pf_d;
  logic            af_q, af_d;
  leaf_t           leaf_q, leaf_d;

  logic level1;
  logic dec_invalid, dec_pointer, dec_leaf_ok, dec_fault;

  assign level1 = (state_q == ST_L1_REQ);

  sv32_pte_decode u_decode (
    .pte     (mem_rdata),
    .level1  (level1),
    .write   (write_q),
    .invalid (dec_invalid),
    .pointer (dec_pointer),
    .leaf_ok (dec_leaf_ok),
    .fault   (dec_fault)
  );

  always_comb begin
    state_d    = state_q;
    vpn0_d     = vpn0_q;
    write_d    = write_q;
    mem_addr_d = mem_addr_q;
    pf_d       = pf_q;
    af_d       = af_q;
    leaf_d     = leaf_q;
    case (state_q)
      ST_IDLE: begin
        if (walk_req) begin
          state_d    = ST_L1_REQ;
          vpn0_d     = walk_vpn[9:0];
          write_d    = walk_write;
          // Index lands in the zeroed page-offset bits, so the add never carries.
          mem_addr_d = (PA_W'(satp_ppn) << PAGE_SHIFT)
                     + (PA_W'(walk_vpn[19:10]) << PTE_SIZE_LOG2);
          pf_d       = 1'b0;
          af_d       = 1'b0;
          leaf_d     = '0;
        end
      end
      ST_L1_REQ, ST_L0_REQ: begin
        if (mem_ack) begin
          if (flush) begin
            state_d = ST_IDLE;
          end else if (mem_err) begin
            af_d    = 1'b1;
            state_d = ST_DONE;
          end else if (dec_invalid || dec_fault) begin
            pf_d    = 1'b1;
            state_d = ST_DONE;
          end else if (dec_pointer) begin
            state_d    = ST_L0_REQ;
            mem_addr_d = (PA_W'(mem_rdata[PTE_PPN_MSB:PTE_PPN_LSB]) << PAGE_SHIFT)
                       + (PA_W'(vpn0_q) << PTE_SIZE_LOG2);
          end else if (dec_leaf_ok) begin
            state_d    = ST_DONE;
            leaf_d.ppn = mem_rdata[PTE_PPN_MSB:PTE_PPN_LSB];
            leaf_d.u   = mem_rdata[PTE_U];
            leaf_d.w   = mem_rdata[PTE_W];
            leaf_d.r   = mem_rdata[PTE_R];
            leaf_d.x   = mem_rdata[PTE_X];
            leaf_d.g   = mem_rdata[PTE_G];
`ifdef SV32_PTW_SUPERPAGE_EN
            leaf_d.sup = level1;
`else
            leaf_d.sup = 1'b0;
`endif
          end
        end else if (flush) begin
          // The outstanding read cannot be withdrawn; wait it out in DRAIN.
          state_d = ST_DRAIN;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_DRAIN: if (mem_ack) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      vpn0_q     <= '0;
      write_q    <= 1'b0;
      mem_addr_q <= '0;
      pf_q       <= 1'b0;
      af_q       <= 1'b0;
      leaf_q     <= '0;
    end else begin
      state_q    <= state_d;
      vpn0_q     <= vpn0_d;
      write_q    <= write_d;
      mem_addr_q <= mem_addr_d;
      pf_q       <= pf_d;
      af_q       <= af_d;
      leaf_q     <= leaf_d;
    end
  end

  assign walk_busy = (state_q != ST_IDLE);
  assign walk_done = (state_q == ST_DONE);
  assign walk_pf   = walk_done && pf_q;
  assign walk_af   = walk_done && af_q;
  assign mem_req   = (state_q == ST_L1_REQ) || (state_q == ST_L0_REQ) || (state_q == ST_DRAIN);
  assign mem_addr  = mem_addr_q;
  assign pte_ppn   = leaf_q.ppn;
  assign pte_u     = leaf_q.u;
  assign pte_w     = leaf_q.w;
  assign pte_r     = leaf_q.r;
  assign pte_x     = leaf_q.x;
  assign pte_g     = leaf_q.g;
  assign pte_super = leaf_q.sup;

endmodule

`default_nettype wire

// File: tb/tb_sv32_ptw.sv
// ============================================================================
// tb_sv32_ptw : scoreboard bench for sv32_ptw with a memory responder model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sv32_ptw;

  localparam int PA_W = 34;
`ifdef SV32_PTW_SUPERPAGE_EN
  localparam bit SUPER = 1'b1;
`else
  localparam bit SUPER = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [21:0]     satp_ppn = '0;
  logic            flush = 1'b0;
  logic            walk_req = 1'b0;
  logic [19:0]     walk_vpn = '0;
  logic            walk_write = 1'b0;
  logic            walk_busy, walk_done, walk_pf, walk_af;
  logic [21:0]     pte_ppn;
  logic            pte_u, pte_w, pte_r, pte_x, pte_g, pte_super;
  logic            mem_req;
  logic [PA_W-1:0] mem_addr;
  logic            mem_ack = 1'b0;
  logic [31:0]     mem_rdata = '0;
  logic            mem_err = 1'b0;

  always #5 clk = ~clk;

  sv32_ptw #(.PA_W(PA_W)) dut (
    .clk(clk), .rst(rst), .satp_ppn(satp_ppn), .flush(flush),
    .walk_req(walk_req), .walk_vpn(walk_vpn), .walk_write(walk_write),
    .walk_busy(walk_busy), .walk_done(walk_done), .walk_pf(walk_pf), .walk_af(walk_af),
    .pte_ppn(pte_ppn), .pte_u(pte_u), .pte_w(pte_w), .pte_r(pte_r), .pte_x(pte_x),
    .pte_g(pte_g), .pte_super(pte_super), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  typedef struct {
    bit          pf;
    bit          af;
    logic [21:0] ppn;
    bit          u, w, r, x, g, sup;
  } exp_t;

  exp_t            exp_q[$];
  logic [PA_W-1:0] addr_q[$];
  logic [31:0]     mem_data [logic [PA_W-1:0]];
  bit              mem_fail [logic [PA_W-1:0]];
  int              checks = 0;
  int              errors = 0;
  int              ack_delay = 0;   // negative selects a random 0..3 delay per request

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Memory responder: acks each request after the configured delay.
  bit pending = 0;
  int cnt = 0;
  always @(negedge clk) begin
    mem_ack   = 1'b0;
    mem_err   = 1'b0;
    mem_rdata = $urandom;
    if (rst || !mem_req) begin
      pending = 0;
    end else begin
      if (!pending) begin
        pending = 1;
        cnt = (ack_delay < 0) ? $urandom_range(0, 3) : ack_delay;
      end
      if (cnt == 0) begin
        pending = 0;
        mem_ack = 1'b1;
        if (addr_q.size() == 0) fail("mem_addr_unexpected_request");
        else chk("mem_addr", mem_addr, addr_q.pop_front());
        mem_rdata = mem_data.exists(mem_addr) ? mem_data[mem_addr] : 32'h0;
        mem_err   = mem_fail.exists(mem_addr) ? mem_fail[mem_addr] : 1'b0;
      end else begin
        cnt--;
      end
    end
  end

  // Result monitor.
  exp_t e_mon;
  always @(negedge clk) begin
    if (!rst && walk_done) begin
      if (exp_q.size() == 0) begin
        fail("unexpected_walk_done");
      end else begin
        e_mon = exp_q.pop_front();
        chk("walk_pf", walk_pf, e_mon.pf);
        chk("walk_af", walk_af, e_mon.af);
        if (!e_mon.pf && !e_mon.af) begin
          chk("pte_ppn", pte_ppn, e_mon.ppn);
          chk("pte_uwrxg", {pte_u, pte_w, pte_r, pte_x, pte_g},
              {e_mon.u, e_mon.w, e_mon.r, e_mon.x, e_mon.g});
          chk("pte_super", pte_super, e_mon.sup);
        end
      end
    end
  end

  // 0 = page fault, 1 = pointer to next level, 2 = usable leaf.
  function automatic int classify(input logic [31:0] p, input bit lvl1, input bit wr);
    if (!p[0] || (!p[1] && p[2])) return 0;
    if (!p[1] && !p[3]) return lvl1 ? 1 : 0;
    if (lvl1 && p[19:10] != 10'd0) return 0;
    if (!p[6] || (wr && !p[7])) return 0;
    if (lvl1 && !SUPER) return 0;
    return 2;
  endfunction

  // Predicts the walk, loads memory, then holds walk_req until accepted.
  task automatic issue(input logic [21:0] satp, input logic [19:0] vpn, input bit wr,
                       input logic [31:0] p1, input bit e1, input logic [31:0] p0, input bit e0,
                       input bit want_result, output int lat);
    logic [PA_W-1:0] a1, a0;
    logic [31:0]     leaf;
    exp_t            e;
    int              n;
    e    = '{default: '0};
    leaf = '0;
    lat  = 2;
    a1   = PA_W'(satp) * 4096 + PA_W'(vpn[19:10]) * 4;
    mem_data[a1] = p1;
    mem_fail[a1] = e1;
    addr_q.push_back(a1);
    if (e1) e.af = 1;
    else if (classify(p1, 1, wr) == 0) e.pf = 1;
    else if (classify(p1, 1, wr) == 2) begin leaf = p1; e.sup = 1; end
    else begin
      lat = 3;
      a0  = PA_W'(p1[31:10]) * 4096 + PA_W'(vpn[9:0]) * 4;
      mem_data[a0] = p0;
      mem_fail[a0] = e0;
      addr_q.push_back(a0);
      if (e0) e.af = 1;
      else if (classify(p0, 0, wr) != 2) e.pf = 1;
      else leaf = p0;
    end
    e.ppn = leaf[31:10];
    e.u = leaf[4]; e.w = leaf[2]; e.r = leaf[1]; e.x = leaf[3]; e.g = leaf[5];
    if (want_result) exp_q.push_back(e);
    satp_ppn = satp; walk_vpn = vpn; walk_write = wr; walk_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(walk_busy && !walk_done) && n < 100);
    if (n >= 100) fail("walk_accept_timeout");
    walk_req = 1'b0;
    satp_ppn = $urandom; walk_vpn = $urandom; walk_write = $urandom;
  endtask

  task automatic finish_walk(input int exp_lat);
    int cyc = 1;
    while (!walk_done && cyc < 200) begin @(negedge clk); cyc++; end
    if (!walk_done) fail("walk_done_timeout");
    else if (exp_lat != 0) chk("done_latency", cyc, exp_lat);
  endtask

  function automatic logic [31:0] gen_pte(input int kind, input bit lvl1);
    logic [31:0] p = $urandom;
    case (kind)
      0: p[3:0] = 4'b0001;
      1: begin p[0] = 1; p[1] = 1; p[6] = 1; p[7] = 1; if (lvl1) p[19:10] = '0; end
      2: p[0] = 0;
      3: p[3:0] = {1'b0, 3'b101};
      4: begin p[0] = 1; p[1] = 1; if (lvl1) p[19:10] = '0; end
      default: ;
    endcase
    return p;
  endfunction

  task automatic random_walk(input bit chk_lat);
    logic [21:0] satp = $urandom;
    logic [31:0] p1, p0;
    int lat;
    satp[21] = 1'b0;
    p1 = gen_pte($urandom_range(0, 5), 1);
    p1[31] = 1'b1;   // keeps level-0 address distinct from level-1 address
    p0 = gen_pte($urandom_range(0, 5), 0);
    issue(satp, $urandom, $urandom, p1, ($urandom_range(0, 9) == 0), p0,
          ($urandom_range(0, 9) == 0), 1, lat);
    finish_walk(chk_lat ? lat : 0);
  endtask

  initial begin
    int lat, n;
    repeat (3) @(negedge clk);
    chk("rst_busy", walk_busy, 0);
    chk("rst_done", walk_done, 0);
    chk("rst_pf_af", {walk_pf, walk_af}, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_pte", {pte_ppn, pte_u, pte_w, pte_r, pte_x, pte_g, pte_super}, 0);
    rst = 1'b0;
    @(negedge clk);

    ack_delay = 0;
    issue(22'h00100, 20'h00401, 0, 32'h00200001, 0, 32'h000400DF, 0, 1, lat);
    finish_walk(lat);
    issue(22'h00100, 20'h00401, 1, 32'h2000004F, 0, 32'h0, 0, 1, lat);
    finish_walk(lat);
    issue(22'h00100, 20'h00401, 0, 32'h2000004F, 0, 32'h0, 0, 1, lat);
    finish_walk(lat);
    issue(22'h00100, 20'h00401, 0, 32'h00000005, 0, 32'h0, 0, 1, lat);
    finish_walk(lat);
    issue(22'h00100, 20'h00401, 0, 32'h000000CF, 1, 32'h0, 0, 1, lat);
    finish_walk(lat);
    issue(22'h00100, 20'h00401, 0, 32'h00200001, 0, 32'h00300001, 0, 1, lat);
    finish_walk(lat);

    // Flush while the level-0 read is outstanding: read must drain, no result.
    ack_delay = 3;
    issue(22'h00123, 20'h12345, 0, 32'h00200001, 0, 32'h000400DF, 0, 0, lat);
    n = 0;
    do begin @(negedge clk); #1; n++; end
    while (!(addr_q.size() == 1 && mem_req && !mem_ack) && n < 50);
    if (n >= 50) fail("flush_l0_wait_timeout");
    flush = 1'b1;
    walk_req = 1'b1;          // ignored: the walker is busy
    walk_vpn = $urandom;
    @(negedge clk); #1;
    flush = 1'b0;
    walk_req = 1'b0;
    n = 0;
    while (walk_busy && n < 50) begin
      chk("drain_mem_req", mem_req, 1);
      @(negedge clk); #1;
      n++;
    end
    chk("drain_idle", walk_busy, 0);
    chk("drain_reads_consumed", addr_q.size(), 0);
    ack_delay = 0;
    issue(22'h00100, 20'h00401, 0, 32'h00200001, 0, 32'h000400DF, 0, 1, lat);
    finish_walk(lat);

    // Flush in the same cycle as a zero-wait level-1 ack: straight to IDLE.
    issue(22'h00321, 20'h00ABC, 0, 32'h0000000F, 0, 32'h0, 0, 0, lat);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ack_idle", walk_busy, 0);
    chk("flush_ack_reads", addr_q.size(), 0);

    // Reset in the middle of a level-1 wait.
    ack_delay = 5;
    issue(22'h00100, 20'h00401, 0, 32'h00200001, 0, 32'h000400DF, 0, 0, lat);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", walk_busy, 0);
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_other", {walk_done, walk_pf, walk_af, pte_ppn, pte_u, pte_w, pte_r,
                          pte_x, pte_g, pte_super}, 0);
    rst = 1'b0;
    addr_q.delete();
    @(negedge clk);

    ack_delay = 0;
    for (int i = 0; i < 150; i++) random_walk(1);
    ack_delay = -1;
    for (int i = 0; i < 150; i++) random_walk(0);

    repeat (4) @(negedge clk);
    chk("results_outstanding", exp_q.size(), 0);
    chk("reads_outstanding", addr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
